// File: rtl/pong_pkg.sv
// Shared Pong match types: state encoding, score width, frame counter width
// and serve direction constants.
package pong_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned FRAME_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_MENU  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_POINT = 3'd4,
    ST_OVER  = 3'd5
  } match_state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/frame_delay.sv
// Loadable frame down-counter; expired marks a tick that arrives with the
// count already at zero. Load takes priority over tick.
module frame_delay
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_val,
  input  logic               tick,
  output logic               expired
);

  logic [FRAME_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - FRAME_W'(1);
    end
  end

  assign expired = tick && (count_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/match_sequencer.sv
// Pong match-level controller: menu/serve/play/pause/point/over sequencing,
// score keeping and serve direction. Define PONG_PAUSE_EN to enable PAUSE.
module match_sequencer
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               playPress,
  input  logic               menuPress,
  input  logic               pausePress,
  input  logic               frameTick,
  input  logic               leftMiss,
  input  logic               rightMiss,
  output logic               engineRun,
  output logic               engineRestart,
  output logic               serveDir,
  output logic [SCORE_W-1:0] scoreLeft,
  output logic [SCORE_W-1:0] scoreRight,
  output logic               gameOver,
  output logic               winner,
  output logic [STATE_W-1:0] matchState
);

  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
  localparam logic [FRAME_W-1:0] SERVE_LD = FRAME_W'(SERVE_FRAMES - 1);
  localparam logic [FRAME_W-1:0] POINT_LD = FRAME_W'(POINT_FRAMES - 1);

  match_state_e       state_q, state_d;
  logic               run_q, run_d;
  logic               restart_q, restart_d;
  logic               dir_q, dir_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic               over_q, over_d;
  logic               winner_q, winner_d;

  logic               restart_ev, new_match, inc_left, inc_right;
  logic               cnt_load, cnt_tick, cnt_expired;
  logic [FRAME_W-1:0] cnt_load_val;

  // Counter reloads on entry so a tick in the entry cycle is never counted.
  assign cnt_load     = (state_d != state_q) && ((state_d == ST_SERVE) || (state_d == ST_POINT));
  assign cnt_load_val = (state_d == ST_SERVE) ? SERVE_LD : POINT_LD;
  assign cnt_tick     = frameTick && ((state_q == ST_SERVE) || (state_q == ST_POINT));

  frame_delay u_frame_delay (
    .clk      (clock),
    .rst_n    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .tick     (cnt_tick),
    .expired  (cnt_expired)
  );

`ifndef PONG_PAUSE_EN
  logic unused_pause;
  assign unused_pause = pausePress;
`endif

  always_comb begin
    state_d    = state_q;
    restart_ev = 1'b0;
    new_match  = 1'b0;
    inc_left   = 1'b0;
    inc_right  = 1'b0;
    if (menuPress) begin
      state_d    = ST_MENU;
      restart_ev = 1'b1;
    end else begin
      unique case (state_q)
        ST_MENU, ST_OVER: begin
          if (playPress) begin
            state_d    = ST_SERVE;
            restart_ev = 1'b1;
            new_match  = 1'b1;
          end
        end
        ST_SERVE: begin
          if (cnt_expired) state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (leftMiss || rightMiss) begin
            state_d   = ST_POINT;
            inc_left  = rightMiss && !leftMiss;
            inc_right = leftMiss && !rightMiss;
          end
`ifdef PONG_PAUSE_EN
          else if (pausePress) begin
            state_d = ST_PAUSE;
          end
`endif
        end
`ifdef PONG_PAUSE_EN
        ST_PAUSE: begin
          if (pausePress || playPress) state_d = ST_PLAY;
        end
`endif
        ST_POINT: begin
          if (cnt_expired) begin
            if ((score_l_q == WIN) || (score_r_q == WIN)) begin
              state_d = ST_OVER;
            end else begin
              state_d    = ST_SERVE;
              restart_ev = 1'b1;
            end
          end
        end
        default: state_d = ST_MENU;
      endcase
    end
  end

  always_comb begin
    run_d     = (state_d == ST_PLAY);
    restart_d = restart_ev;
    over_d    = (state_d == ST_OVER);
    winner_d  = winner_q;
    dir_d     = dir_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    if ((state_d == ST_OVER) && (state_q != ST_OVER)) begin
      winner_d = (score_r_q == WIN);
    end
    if (new_match || (state_d == ST_MENU)) begin
      score_l_d = '0;
      score_r_d = '0;
    end else begin
      if (inc_left && (score_l_q < WIN)) score_l_d = score_l_q + SCORE_W'(1);
      if (inc_right && (score_r_q < WIN)) score_r_d = score_r_q + SCORE_W'(1);
    end
    // Next serve goes toward whoever conceded the point.
    if (new_match) begin
      dir_d = DIR_RIGHT;
    end else if (inc_left) begin
      dir_d = DIR_RIGHT;
    end else if (inc_right) begin
      dir_d = DIR_LEFT;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_MENU;
      run_q     <= 1'b0;
      restart_q <= 1'b0;
      dir_q     <= DIR_RIGHT;
      score_l_q <= '0;
      score_r_q <= '0;
      over_q    <= 1'b0;
      winner_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      restart_q <= restart_d;
      dir_q     <= dir_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      over_q    <= over_d;
      winner_q  <= winner_d;
    end
  end

  assign engineRun     = run_q;
  assign engineRestart = restart_q;
  assign serveDir      = dir_q;
  assign scoreLeft     = score_l_q;
  assign scoreRight    = score_r_q;
  assign gameOver      = over_q;
  assign winner        = winner_q;
  assign matchState    = state_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed table-driven bench for match_sequencer with default frame counts.
module tb_match_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       playPress = 1'b0, menuPress = 1'b0, pausePress = 1'b0;
  logic       frameTick = 1'b0, leftMiss = 1'b0, rightMiss = 1'b0;
  logic       engineRun, engineRestart, serveDir, gameOver, winner;
  logic [3:0] scoreLeft, scoreRight;
  logic [2:0] matchState;

  match_sequencer #(
    .WIN_SCORE    (7),
    .SERVE_FRAMES (60),
    .POINT_FRAMES (90)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .playPress     (playPress),
    .menuPress     (menuPress),
    .pausePress    (pausePress),
    .frameTick     (frameTick),
    .leftMiss      (leftMiss),
    .rightMiss     (rightMiss),
    .engineRun     (engineRun),
    .engineRestart (engineRestart),
    .serveDir      (serveDir),
    .scoreLeft     (scoreLeft),
    .scoreRight    (scoreRight),
    .gameOver      (gameOver),
    .winner        (winner),
    .matchState    (matchState)
  );

  always #5 clock = ~clock;

  localparam logic [2:0] S_MENU = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2;
  localparam logic [2:0] S_POINT = 3'd4, S_OVER = 3'd5;
`ifdef PONG_PAUSE_EN
  localparam logic [2:0] S_PAUSED   = 3'd3;
  localparam logic       RUN_PAUSED = 1'b0;
`else
  localparam logic [2:0] S_PAUSED   = 3'd2;
  localparam logic       RUN_PAUSED = 1'b1;
`endif

  // Input bits: {play, menu, pause, tick, leftMiss, rightMiss}
  localparam logic [5:0] I_NONE = 6'b000000, I_PLAY = 6'b100000, I_MENU = 6'b010000;
  localparam logic [5:0] I_PAUSE = 6'b001000, I_TICK = 6'b000100;
  localparam logic [5:0] I_LM = 6'b000010, I_RM = 6'b000001;

  typedef struct {
    string       name;
    int unsigned rpt;
    logic [5:0]  in;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Output packing: {state[15:13], run, restart, dir, left[9:6], right[5:2], over, winner}
  function automatic logic [15:0] pk(logic [2:0] st, logic run, logic rst, logic dir,
                                     logic [3:0] sl, logic [3:0] sr, logic over, logic win);
    return {st, run, rst, dir, sl, sr, over, win};
  endfunction

  function automatic void add(string name, int unsigned rpt, logic [5:0] in, logic [15:0] exp);
    vec_t v;
    v.name = name;
    v.rpt  = rpt;
    v.in   = in;
    v.exp  = exp;
    vecs.push_back(v);
  endfunction

  task automatic cyc(logic [5:0] in);
    {playPress, menuPress, pausePress, frameTick, leftMiss, rightMiss} = in;
    @(posedge clock);
    #1;
    {playPress, menuPress, pausePress, frameTick, leftMiss, rightMiss} = '0;
  endtask

  task automatic check(string name, logic [15:0] exp, logic full);
    logic [15:0] act, mask;
    act  = {matchState, engineRun, engineRestart, serveDir, scoreLeft, scoreRight, gameOver, winner};
    // winner is only meaningful while gameOver is high
    mask = (full || exp[1]) ? 16'hFFFF : 16'hFFFE;
    n_vec++;
    if ((act & mask) !== (exp & mask)) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (st,run,rst,dir,L,R,over,win)", name, act & mask, exp & mask);
    end
  endtask

  initial begin
    add("idle_menu",   1,  I_NONE,          pk(S_MENU, 0, 0, 1, 0, 0, 0, 0));
    add("play_enter",  1,  I_PLAY | I_TICK, pk(S_SERVE, 0, 1, 1, 0, 0, 0, 0));
    add("serve_hold",  1,  I_NONE,          pk(S_SERVE, 0, 0, 1, 0, 0, 0, 0));
    add("serve_59",    59, I_TICK,          pk(S_SERVE, 0, 0, 1, 0, 0, 0, 0));
    add("serve_60",    1,  I_TICK,          pk(S_PLAY, 1, 0, 1, 0, 0, 0, 0));
    add("rmiss",       1,  I_RM,            pk(S_POINT, 0, 0, 1, 1, 0, 0, 0));
    add("point_89",    89, I_TICK,          pk(S_POINT, 0, 0, 1, 1, 0, 0, 0));
    add("point_90",    1,  I_TICK,          pk(S_SERVE, 0, 1, 1, 1, 0, 0, 0));
    add("serve_full",  60, I_TICK,          pk(S_PLAY, 1, 0, 1, 1, 0, 0, 0));
    add("lmiss",       1,  I_LM,            pk(S_POINT, 0, 0, 0, 1, 1, 0, 0));
    add("point_full",  90, I_TICK,          pk(S_SERVE, 0, 1, 0, 1, 1, 0, 0));
    add("serve_full2", 60, I_TICK,          pk(S_PLAY, 1, 0, 0, 1, 1, 0, 0));
    add("both_miss",   1,  I_LM | I_RM,     pk(S_POINT, 0, 0, 0, 1, 1, 0, 0));
    add("point_full2", 90, I_TICK,          pk(S_SERVE, 0, 1, 0, 1, 1, 0, 0));
    add("serve_full3", 60, I_TICK,          pk(S_PLAY, 1, 0, 0, 1, 1, 0, 0));
    add("pause_on",    1,  I_PAUSE,         pk(S_PAUSED, RUN_PAUSED, 0, 0, 1, 1, 0, 0));
    add("pause_ticks", 100, I_TICK,         pk(S_PAUSED, RUN_PAUSED, 0, 0, 1, 1, 0, 0));
    add("pause_off",   1,  I_PAUSE,         pk(S_PLAY, 1, 0, 0, 1, 1, 0, 0));
    add("menu_rm_play", 1, I_MENU | I_RM,   pk(S_MENU, 0, 1, 0, 0, 0, 0, 0));
    add("menu_idle",   1,  I_NONE,          pk(S_MENU, 0, 0, 0, 0, 0, 0, 0));
    add("new_match",   1,  I_PLAY,          pk(S_SERVE, 0, 1, 1, 0, 0, 0, 0));
    add("serve_10",    10, I_TICK,          pk(S_SERVE, 0, 0, 1, 0, 0, 0, 0));
    add("menu_rm_serve", 1, I_MENU | I_RM,  pk(S_MENU, 0, 1, 1, 0, 0, 0, 0));
    add("new_match2",  1,  I_PLAY,          pk(S_SERVE, 0, 1, 1, 0, 0, 0, 0));
    add("serve_full4", 60, I_TICK,          pk(S_PLAY, 1, 0, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 7; k++) begin
      add("lw_miss", 1, (k == 1) ? (I_RM | I_PAUSE | I_PLAY) : I_RM,
          pk(S_POINT, 0, 0, 1, 4'(k), 0, 0, 0));
      if (k < 7) begin
        add("lw_hold",  90, I_TICK, pk(S_SERVE, 0, 1, 1, 4'(k), 0, 0, 0));
        add("lw_serve", 60, I_TICK, pk(S_PLAY, 1, 0, 1, 4'(k), 0, 0, 0));
      end else begin
        add("lw_over",  90, I_TICK, pk(S_OVER, 0, 0, 1, 7, 0, 1, 0));
      end
    end
    add("over_hold",   5,  I_TICK | I_RM | I_LM | I_PAUSE, pk(S_OVER, 0, 0, 1, 7, 0, 1, 0));
    add("over_play",   1,  I_PLAY,          pk(S_SERVE, 0, 1, 1, 0, 0, 0, 0));
    add("serve_full5", 60, I_TICK,          pk(S_PLAY, 1, 0, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 7; k++) begin
      add("rw_miss", 1, I_LM, pk(S_POINT, 0, 0, 0, 0, 4'(k), 0, 0));
      if (k < 7) begin
        add("rw_hold",  90, I_TICK, pk(S_SERVE, 0, 1, 0, 0, 4'(k), 0, 0));
        add("rw_serve", 60, I_TICK, pk(S_PLAY, 1, 0, 0, 0, 4'(k), 0, 0));
      end else begin
        add("rw_over",  90, I_TICK, pk(S_OVER, 0, 0, 0, 0, 7, 1, 1));
      end
    end
    add("over_menu",   1,  I_MENU,          pk(S_MENU, 0, 1, 0, 0, 0, 0, 0));
    add("menu_play",   1,  I_PLAY,          pk(S_SERVE, 0, 1, 1, 0, 0, 0, 0));
    add("serve_full6", 60, I_TICK,          pk(S_PLAY, 1, 0, 1, 0, 0, 0, 0));
    add("rmiss2",      1,  I_RM,            pk(S_POINT, 0, 0, 1, 1, 0, 0, 0));
    add("point_40",    40, I_TICK,          pk(S_POINT, 0, 0, 1, 1, 0, 0, 0));

    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_vals", pk(S_MENU, 0, 0, 1, 0, 0, 0, 0), 1'b1);
    reset = 1'b1;

    foreach (vecs[i]) begin
      repeat (vecs[i].rpt) cyc(vecs[i].in);
      check(vecs[i].name, vecs[i].exp, 1'b0);
    end

    // Reset mid-POINT overrides every other input on the same edge.
    reset = 1'b0;
    cyc(I_PLAY | I_MENU | I_TICK | I_RM);
    check("reset_in_point", pk(S_MENU, 0, 0, 1, 0, 0, 0, 0), 1'b1);
    reset = 1'b1;
    cyc(I_NONE);
    check("post_reset_idle", pk(S_MENU, 0, 0, 1, 0, 0, 0, 0), 1'b1);

    // SERVE counts ticks, not cycles: sparse ticks still need all 60.
    cyc(I_PLAY);
    check("gap_enter", pk(S_SERVE, 0, 1, 1, 0, 0, 0, 0), 1'b0);
    for (int i = 0; i < 59; i++) begin
      cyc(I_TICK);
      cyc(I_NONE);
      cyc(I_NONE);
    end
    check("gap_59", pk(S_SERVE, 0, 0, 1, 0, 0, 0, 0), 1'b0);
    cyc(I_TICK);
    check("gap_60", pk(S_PLAY, 1, 0, 1, 0, 0, 0, 0), 1'b0);
    cyc(I_NONE);
    check("gap_play_hold", pk(S_PLAY, 1, 0, 1, 0, 0, 0, 0), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
